// File: rtl/noise_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : noise_step_scheduler
// Description : Sequences Gaussian pairs from an RNG stream through an
//               external correlated_noise block and presents the resulting
//               correlated increments (dW1, dW2) to a Heston path update,
//               one increment per (path, step) in path-major order.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start, abort          run control (abort wins over everything but rst)
//   num_paths, num_steps  run dimensions, latched on an accepted start
//   rho, dt               correlation / timestep, latched on accepted start
//   z_valid/z_ready/z1/z2 Gaussian pair input stream (valid/ready)
//   noise_*               drive to / results from correlated_noise
//   dw_valid/dw_ready/dw1/dw2  increment output stream (valid/ready)
//   path_idx, step_idx    indices of the increment on dw
//   last_step, last_path  end-of-path / last-path flags, qualified by dw_valid
//   busy, done            run in progress / one-cycle completion pulse
//
// Revision    : 1.0 - initial release
// ============================================================================
module noise_step_scheduler #(
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] num_paths,
    input  logic [CW-1:0] num_steps,
    input  logic [W-1:0]  rho,
    input  logic [W-1:0]  dt,
    input  logic          z_valid,
    output logic          z_ready,
    input  logic [W-1:0]  z1,
    input  logic [W-1:0]  z2,
    output logic          noise_en,
    output logic [W-1:0]  noise_z1,
    output logic [W-1:0]  noise_z2,
    output logic [W-1:0]  noise_rho,
    output logic [W-1:0]  noise_dt,
    input  logic [W-1:0]  noise_dw1,
    input  logic [W-1:0]  noise_dw2,
    output logic          dw_valid,
    input  logic          dw_ready,
    output logic [W-1:0]  dw1,
    output logic [W-1:0]  dw2,
    output logic [CW-1:0] path_idx,
    output logic [CW-1:0] step_idx,
    output logic          last_step,
    output logic          last_path,
    output logic          busy,
    output logic          done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_FIRE  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_OFFER = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [CW-1:0] c_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [2:0]    r_state;
    logic [2:0]    w_next_state;

    logic [CW-1:0] r_num_paths;
    logic [CW-1:0] r_num_steps;
    logic [W-1:0]  r_rho;
    logic [W-1:0]  r_dt;
    logic [W-1:0]  r_z1;
    logic [W-1:0]  r_z2;
    logic [CW-1:0] r_path_idx;
    logic [CW-1:0] r_step_idx;

    logic          w_zero_cfg;
    logic          w_step_last;
    logic          w_path_last;
    logic          w_offer;

    // A zero count in either dimension means an empty run.
    assign w_zero_cfg  = (num_paths == '0) || (num_steps == '0);

    // Counts are non-zero whenever these are consulted (a zero count never
    // leaves IDLE except to DONE), so count-1 cannot underflow and a count of
    // 2^CW-1 terminates on its last index without the counter wrapping.
    assign w_step_last = (r_step_idx == (r_num_steps - c_ONE));
    assign w_path_last = (r_path_idx == (r_num_paths - c_ONE));
    assign w_offer     = (r_state == S_OFFER);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_next_state = w_zero_cfg ? S_DONE : S_FETCH;
                S_FETCH: if (z_valid) w_next_state = S_FIRE;
                S_FIRE:  w_next_state = S_WAIT;
                // One idle cycle lets correlated_noise's output register load.
                S_WAIT:  w_next_state = S_OFFER;
                S_OFFER: begin
                    if (dw_ready) begin
                        w_next_state = (w_step_last && w_path_last) ? S_DONE : S_FETCH;
                    end
                end
                S_DONE:  w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Configuration, captured samples and index counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_num_paths <= '0;
            r_num_steps <= '0;
            r_rho       <= '0;
            r_dt        <= '0;
            r_z1        <= '0;
            r_z2        <= '0;
            r_path_idx  <= '0;
            r_step_idx  <= '0;
        end else if (!abort) begin
            if ((r_state == S_IDLE) && start) begin
                r_num_paths <= num_paths;
                r_num_steps <= num_steps;
                r_rho       <= rho;
                r_dt        <= dt;
                r_path_idx  <= '0;
                r_step_idx  <= '0;
            end

            if ((r_state == S_FETCH) && z_valid) begin
                r_z1 <= z1;
                r_z2 <= z2;
            end

            if (w_offer && dw_ready) begin
                if (!w_step_last) begin
                    r_step_idx <= r_step_idx + c_ONE;
                end else begin
                    r_step_idx <= '0;
                    if (!w_path_last) begin
                        r_path_idx <= r_path_idx + c_ONE;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        z_ready   = (r_state == S_FETCH);
        noise_en  = (r_state == S_FIRE);
        dw_valid  = w_offer;
        // correlated_noise holds its outputs while noise_en is low, so the
        // pass-through stays constant for as long as OFFER is stalled.
        dw1       = w_offer ? noise_dw1 : '0;
        dw2       = w_offer ? noise_dw2 : '0;
        last_step = w_offer && w_step_last;
        last_path = w_offer && w_path_last;
    end

    assign noise_z1  = r_z1;
    assign noise_z2  = r_z2;
    assign noise_rho = r_rho;
    assign noise_dt  = r_dt;
    assign path_idx  = r_path_idx;
    assign step_idx  = r_step_idx;

endmodule
`default_nettype wire

// File: tb/tb_noise_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_noise_step_scheduler
// Description : Directed self-checking bench for noise_step_scheduler with a
//               behavioural correlated_noise and a counting Gaussian source.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noise_step_scheduler;

    localparam int W  = 32;
    localparam int CW = 16;
    localparam logic [W-1:0] c_RHO = 32'h0080_0000;  // 0.5
    localparam logic [W-1:0] c_DT  = 32'd167772;     // 0.01

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [CW-1:0] num_paths, num_steps;
    logic [W-1:0]  rho, dt;
    logic          z_valid, z_ready;
    logic [W-1:0]  z1, z2;
    logic          noise_en;
    logic [W-1:0]  noise_z1, noise_z2, noise_rho, noise_dt;
    logic [W-1:0]  noise_dw1, noise_dw2;
    logic          dw_valid, dw_ready;
    logic [W-1:0]  dw1, dw2;
    logic [CW-1:0] path_idx, step_idx;
    logic          last_step, last_path, busy, done;

    int n_err = 0;
    int n_checks = 0;
    int zi = 0;
    int nhs, nen, ndone, last_hs, noff;
    logic seen;
    logic [W-1:0] nd1, nd2;

    always #5 clk = ~clk;

    noise_step_scheduler #(.W(W), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num_paths(num_paths), .num_steps(num_steps), .rho(rho), .dt(dt),
        .z_valid(z_valid), .z_ready(z_ready), .z1(z1), .z2(z2),
        .noise_en(noise_en), .noise_z1(noise_z1), .noise_z2(noise_z2),
        .noise_rho(noise_rho), .noise_dt(noise_dt),
        .noise_dw1(noise_dw1), .noise_dw2(noise_dw2),
        .dw_valid(dw_valid), .dw_ready(dw_ready), .dw1(dw1), .dw2(dw2),
        .path_idx(path_idx), .step_idx(step_idx),
        .last_step(last_step), .last_path(last_path),
        .busy(busy), .done(done)
    );

    function automatic real fx2r(input logic [W-1:0] v);
        return $itor($signed(v)) / 16777216.0;
    endfunction

    function automatic logic [W-1:0] r2fx(input real r);
        return 32'($rtoi(r * 16777216.0));
    endfunction

    // Gaussian source: k-th pair is z1=(k%16+1)*0.5, z2=-z1/2
    function automatic logic [W-1:0] zval1(input int k);
        return 32'(((k % 16) + 1) * 8388608);
    endfunction

    function automatic logic [W-1:0] zval2(input int k);
        return 32'(-((k % 16) + 1) * 4194304);
    endfunction

    function automatic logic near(input logic [W-1:0] a, input real e);
        real d;
        d = fx2r(a) - e;
        if (d < 0.0) d = -d;
        return (d * 16777216.0) < 2000.0;
    endfunction

    always_comb begin
        z1 = zval1(zi);
        z2 = zval2(zi);
    end

    always @(posedge clk) begin
        if (z_valid && z_ready) zi <= zi + 1;
    end

    // Behavioural correlated_noise: registered, loads only when en is high.
    always @(posedge clk) begin
        if (rst) begin
            nd1 <= '0;
            nd2 <= '0;
        end else if (noise_en) begin
            nd1 <= r2fx(fx2r(noise_z1) * $sqrt(fx2r(noise_dt)));
            nd2 <= r2fx((fx2r(noise_rho) * fx2r(noise_z1)
                   + $sqrt(1.0 - fx2r(noise_rho) * fx2r(noise_rho)) * fx2r(noise_z2))
                   * $sqrt(fx2r(noise_dt)));
        end
    end
    assign noise_dw1 = nd1;
    assign noise_dw2 = nd2;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [CW-1:0] np, input logic [CW-1:0] ns);
        num_paths = np;
        num_steps = ns;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done(input string tag);
        logic got;
        got = 1'b0;
        z_valid = 1'b1;
        dw_ready = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            if (done) got = 1'b1;
            tick();
        end
        check(tag, got, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        num_paths = '0; num_steps = '0; rho = c_RHO; dt = c_DT;
        z_valid = 1'b0; dw_ready = 1'b0;
        tick(); tick(); tick();

        // Reset state
        check("rst_ctl", {busy, done, z_ready, noise_en, dw_valid, last_step, last_path}, 7'b0);
        check("rst_dw1", dw1, 0);
        check("rst_nz1", noise_z1, 0);
        check("rst_rho", noise_rho, 0);
        check("rst_dt", noise_dt, 0);
        check("rst_idx", {path_idx, step_idx}, 0);
        rst = 1'b0;
        tick();

        // Main run: 2 paths x 3 steps, free-flowing handshakes
        z_valid = 1'b1; dw_ready = 1'b1;
        pulse_start(2, 3);
        nhs = 0; nen = 0; ndone = 0; last_hs = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (noise_en) begin
                nen++;
                check("main_fire_z1", noise_z1, zval1(zi - 1));
            end
            if (dw_valid) begin
                check("main_idx", {path_idx, step_idx}, {16'(nhs / 3), 16'(nhs % 3)});
                check("main_last", {last_step, last_path}, {(nhs % 3 == 2), (nhs / 3 == 1)});
                check("main_dw1", near(dw1, fx2r(zval1(zi - 1)) * 0.1), 1'b1);
                check("main_dw2", near(dw2, (0.5 * fx2r(zval1(zi - 1))
                      + $sqrt(0.75) * fx2r(zval2(zi - 1))) * 0.1), 1'b1);
                if (nhs > 0) check("main_gap", cyc - last_hs, 4);
                last_hs = cyc;
                nhs++;
            end else begin
                check("main_flags_idle", {last_step, last_path}, 2'b00);
            end
            if (done) ndone++;
            tick();
        end
        check("main_incs", nhs, 6);
        check("main_fires", nen, 6);
        check("main_done_cnt", ndone, 1);
        check("main_idle", {busy, z_ready}, 2'b00);
        check("main_rho_hold", noise_rho, c_RHO);
        check("main_dt_hold", noise_dt, c_DT);

        // Back-pressure in OFFER
        dw_ready = 1'b0;
        pulse_start(1, 2);
        for (int i = 0; i < 20 && !dw_valid; i++) tick();
        check("stall_reach", dw_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("stall_ctl", {dw_valid, noise_en, z_ready}, 3'b100);
            check("stall_idx", {path_idx, step_idx}, 0);
            check("stall_dw1", dw1, nd1);
            check("stall_dw2", dw2, nd2);
            check("stall_near", near(dw1, fx2r(zval1(zi - 1)) * 0.1), 1'b1);
            tick();
        end
        run_to_done("stall_done");

        // Gaps on the z stream
        z_valid = 1'b0; dw_ready = 1'b1;
        pulse_start(1, 1);
        for (int i = 0; i < 3; i++) begin
            check("gap_fetch", {busy, z_ready, noise_en, dw_valid}, 4'b1100);
            tick();
        end
        z_valid = 1'b1;
        tick();
        z_valid = 1'b0;
        check("gap_fire", noise_en, 1'b1);
        check("gap_z1", noise_z1, zval1(zi - 1));
        check("gap_z2", noise_z2, zval2(zi - 1));
        run_to_done("gap_done");

        // Empty run
        z_valid = 1'b1;
        pulse_start(5, 0);
        check("zero_c0", {busy, done, z_ready, dw_valid}, 4'b1100);
        tick();
        check("zero_c1", {busy, done, z_ready, dw_valid}, 4'b0000);

        // Abort in OFFER of the second increment, with dw_ready high
        dw_ready = 1'b1;
        pulse_start(1, 4);
        noff = 0;
        for (int i = 0; i < 20 && noff < 2; i++) begin
            if (dw_valid) noff++;
            if (noff < 2) tick();
        end
        check("abort_reach", noff, 2);
        check("abort_idx", step_idx, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_out", {busy, done, dw_valid, z_ready, noise_en}, 5'b0);
        for (int i = 0; i < 3; i++) begin
            check("abort_nodone", {busy, done}, 2'b00);
            tick();
        end
        pulse_start(1, 1);
        for (int i = 0; i < 20 && !dw_valid; i++) tick();
        check("rerun_idx", {path_idx, step_idx}, 0);
        check("rerun_last", {last_step, last_path}, 2'b11);
        run_to_done("rerun_done");

        // Start ignored while busy, then reset mid-FIRE
        z_valid = 1'b0; dw_ready = 1'b1; rho = c_RHO;
        pulse_start(2, 2);
        num_paths = 7; num_steps = 1; rho = 32'h0040_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_state", {busy, z_ready}, 2'b11);
        check("ign_rho", noise_rho, c_RHO);
        z_valid = 1'b1;
        for (int i = 0; i < 20 && !dw_valid; i++) tick();
        check("ign_last", {last_step, last_path}, 2'b00);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (noise_en) seen = 1'b1;
        end
        check("rst_fire_reach", {seen, step_idx}, {1'b1, 16'd1});
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("mrst_ctl", {busy, done, z_ready, noise_en, dw_valid, last_step, last_path}, 7'b0);
        check("mrst_dw", {dw1, dw2}, 0);
        check("mrst_nz", {noise_z1, noise_z2}, 0);
        check("mrst_cfg", {noise_rho, noise_dt}, 0);
        check("mrst_idx", {path_idx, step_idx}, 0);
        tick();
        check("mrst_stay_idle", {busy, done}, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/noise_step_scheduler.md
NOISE_STEP_SCHEDULER -- requirements
Module: noise_step_scheduler

Interface
REQ-001 Parameter: W, 32, fixed-point data width (Q8.24 signed for z, rho, dw; Q8.24 unsigned for dt).
REQ-002 Parameter: CW, 16, width of path/step counters and count inputs.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  pulse; begins a run when FSM is IDLE.
REQ-006 abort  in  1  terminates a run; returns to IDLE without done.
REQ-007 num_paths, num_steps  in  CW each  run dimensions, latched on accepted start.
REQ-008 rho, dt  in  W each  correlation and timestep, latched on accepted start.
REQ-009 z_valid in 1, z_ready out 1, z1 in W, z2 in W  Gaussian pair stream from RNG, valid/ready.
REQ-010 noise_en out 1, noise_z1 out W, noise_z2 out W, noise_rho out W, noise_dt out W  drive to correlated_noise.
REQ-011 noise_dw1, noise_dw2  in  W each  registered outputs of correlated_noise (1-cycle latency after en, held while en=0).
REQ-012 dw_valid out 1, dw_ready in 1, dw1 out W, dw2 out W  correlated increment stream to Heston update, valid/ready.
REQ-013 path_idx, step_idx  out  CW each  indices of the increment currently offered on dw.
REQ-014 last_step, last_path  out  1 each  flags qualified by dw_valid.
REQ-015 busy out 1 (FSM not IDLE); done out 1 (single-cycle pulse at run completion).

Function
REQ-016 FSM states SHALL be IDLE, FETCH, FIRE, WAIT, OFFER, DONE.
REQ-017 IDLE: start=1 latches num_paths, num_steps, rho, dt, clears path_idx/step_idx, goes to FETCH; if either count is 0, goes to DONE instead.
REQ-018 start while not IDLE SHALL be ignored.
REQ-019 FETCH: z_ready=1; on z_valid&z_ready capture z1/z2 into internal regs and go to FIRE; z_ready=0 in every other state.
REQ-020 FIRE: noise_en=1 for exactly one cycle with captured z and latched rho/dt; next state WAIT.
REQ-021 WAIT: noise_en=0 for one cycle; next state OFFER (covers correlated_noise output register latency).
REQ-022 OFFER: dw_valid=1, dw1/dw2 = noise_dw1/noise_dw2 (stable since noise_en=0); dw, indices and flags SHALL be held constant until dw_ready=1.
REQ-023 On dw_valid&dw_ready: if step_idx<num_steps-1, step_idx+1 and go to FETCH; else step_idx=0, and if path_idx<num_paths-1, path_idx+1 and go to FETCH; else go to DONE.
REQ-024 last_step=(step_idx==num_steps-1); last_path=(path_idx==num_paths-1); both 0 when dw_valid=0.
REQ-025 DONE: done=1 for one cycle, next state IDLE; latched config and indices retained until next start.
REQ-026 noise_en SHALL be high only in FIRE; minimum 4 cycles per increment with z_valid and dw_ready held high.
REQ-027 abort=1 in any state SHALL force IDLE on the next edge, deassert z_ready/dw_valid/noise_en, no done pulse; abort takes priority over start and over handshakes in the same cycle.
REQ-028 noise_rho/noise_dt SHALL output latched values at all times; noise_z1/noise_z2 output captured z registers.
REQ-029 Counters SHALL use CW-bit unsigned compare; num_steps or num_paths = 2^CW-1 SHALL complete without wrap.

Reset
REQ-030 rst=1 SHALL, at the next edge, force IDLE and clear all registers: busy, done, z_ready, noise_en, dw_valid, last_step, last_path = 0; dw1, dw2, noise_z1, noise_z2, noise_rho, noise_dt, path_idx, step_idx = 0.
REQ-031 rst SHALL override start, abort and all handshakes; reset mid-run discards in-flight increment with no done.

Verification
REQ-032 num_paths=2, num_steps=3, rho=0.5, dt=0.01, z_valid and dw_ready always 1 -> 6 increments, indices (0,0)(0,1)(0,2)(1,0)(1,1)(1,2), last_step on 3rd/6th, last_path on 4th-6th, done once, 4 cycles per increment, dw1 = z1*0.1 within 2000 LSB.
REQ-033 dw_ready held 0 for 5 cycles in OFFER -> dw1, dw2, indices held constant, noise_en stays 0, no z_ready.
REQ-034 z_valid gaps of 3 cycles -> FSM stays in FETCH, noise_en never pulses without prior z handshake.
REQ-035 start with num_steps=0 -> busy 1 cycle, done pulse, no z_ready, no dw_valid.
REQ-036 abort asserted in OFFER of 2nd increment -> IDLE next cycle, dw_valid=0, no done; subsequent start runs cleanly from (0,0).
REQ-037 rst asserted mid-FIRE -> all outputs 0 next cycle; start pulse during busy ignored (config unchanged).
